hazard_ctrl: RTL



---
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: load-use stalls,
// taken-branch redirects and multi-cycle EX holds, plus stall/flush counters.
module hazard_ctrl #(
    parameter int LU_BUBBLES = 1,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_target,
    input  logic             mc_start,
    input  logic             mc_done,
    output logic             stall,
    output logic             flush,
    output logic             PCsrc,
    output logic [31:0]      pc_b,
    output logic             idex_bubble,
    output logic             mc_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int LU_W = $clog2(LU_BUBBLES + 1);
    localparam int WD_W = $clog2(MC_TIMEOUT + 1);
    localparam bit LU_MULTI = (LU_BUBBLES > 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [LU_W-1:0]  LU_LOAD  = LU_W'(LU_BUBBLES - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(MC_TIMEOUT - 2);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MC_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LU_W-1:0]   r_lu_cnt;
    logic [LU_W-1:0]   w_lu_cnt_nxt;
    logic [WD_W-1:0]   r_wd;
    logic [WD_W-1:0]   w_wd_nxt;
    logic              r_mc_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_lu_hit;
    logic              w_stall;
    logic              w_flush;
    logic              w_pcsrc;
    logic              w_bubble;
    logic              w_wd_fire;

    // A load in EX whose destination feeds the ID instruction; x0 never hazards.
    assign w_lu_hit = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    // Next-state and zero-latency control outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_lu_cnt_nxt = r_lu_cnt;
        w_wd_nxt     = r_wd;
        w_stall      = 1'b0;
        w_flush      = 1'b0;
        w_pcsrc      = 1'b0;
        w_bubble     = 1'b0;
        w_wd_fire    = 1'b0;
        if (rst) begin
            w_state_nxt  = ST_RUN;
            w_lu_cnt_nxt = '0;
            w_wd_nxt     = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        // Wrong-path instruction is killed, so its hazards don't matter.
                        w_flush  = 1'b1;
                        w_pcsrc  = 1'b1;
                        w_bubble = 1'b1;
                    end else if (mc_start && !mc_done) begin
                        w_stall     = 1'b1;
                        w_wd_nxt    = '0;
                        w_state_nxt = ST_MC_WAIT;
                    end else if (w_lu_hit) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                        if (LU_MULTI) begin
                            w_lu_cnt_nxt = LU_LOAD;
                            w_state_nxt  = ST_LU_STALL;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_LU_STALL: begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    if (r_lu_cnt <= LU_W'(1)) begin
                        w_lu_cnt_nxt = '0;
                        w_state_nxt  = ST_RUN;
                    end else begin
                        w_lu_cnt_nxt = r_lu_cnt - LU_W'(1);
                    end
                end
                ST_MC_WAIT: begin
                    if (mc_done) begin
                        w_state_nxt = ST_RUN;
                    end else if (r_wd >= WD_LIMIT) begin
                        // Watchdog step would reach MC_TIMEOUT-1: abort and release fetch.
                        w_wd_fire   = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_stall  = 1'b1;
                        w_wd_nxt = r_wd + WD_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // State, bubble counter, watchdog, sticky error and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_lu_cnt    <= '0;
            r_wd        <= '0;
            r_mc_err    <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lu_cnt <= w_lu_cnt_nxt;
            r_wd     <= w_wd_nxt;
            if (w_wd_fire) begin
                r_mc_err <= 1'b1;
            end else begin
                r_mc_err <= r_mc_err;
            end
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stall       = w_stall;
    assign flush       = w_flush;
    assign PCsrc       = w_pcsrc;
    assign pc_b        = w_pcsrc ? ex_branch_target : 32'd0;
    assign idex_bubble = w_bubble;
    // Error is visible in the same cycle the watchdog fires, then held.
    assign mc_err      = r_mc_err | w_wd_fire;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
